// File: rtl/writeback_arbiter_if.sv
// Completion-request bundle between the functional units and the writeback arbiter.
// Each unit has one lane: done/rd/rd_data/id flow toward the arbiter and ack flows back.
interface writeback_arbiter_if #(
    parameter int NUM_WB_UNITS = 4,
    parameter int ID_W         = 3
);
    logic [NUM_WB_UNITS-1:0]            unit_done;
    logic [NUM_WB_UNITS-1:0][4:0]       unit_rd;
    logic [NUM_WB_UNITS-1:0][31:0]      unit_rd_data;
    logic [NUM_WB_UNITS-1:0][ID_W-1:0]  unit_id;
    logic [NUM_WB_UNITS-1:0]            unit_ack;

    // Functional units drive requests and watch for their grant.
    modport master (
        output unit_done, unit_rd, unit_rd_data, unit_id,
        input  unit_ack
    );

    // The arbiter consumes requests and returns a one-hot grant.
    modport slave (
        input  unit_done, unit_rd, unit_rd_data, unit_id,
        output unit_ack
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: picks at most one functional-unit completion per cycle using
// round-robin priority and drives the register file write port one cycle later.
// The grant (unit_ack) is combinational; everything facing the register file is registered.
// Optional macro WB_PERF_COUNTERS_EN adds per-unit stall counters and a retirement
// counter; without it the counter outputs are tied to zero and no counter flops exist.
module writeback_arbiter #(
    parameter int NUM_WB_UNITS = 4,
    parameter int ID_W         = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    writeback_arbiter_if.slave             units,
    output logic [4:0]                     rd_addr,
    output logic [31:0]                    new_data,
    output logic                           commit,
    output logic                           retire_valid,
    output logic [ID_W-1:0]                retire_id,
    output logic [NUM_WB_UNITS-1:0][31:0]  perf_stall_cnt,
    output logic [31:0]                    perf_commit_cnt
);

    localparam int               PTR_W = (NUM_WB_UNITS > 1) ? $clog2(NUM_WB_UNITS) : 1;
    localparam logic [PTR_W:0]   NUM_W = (PTR_W+1)'(NUM_WB_UNITS);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_WB_UNITS - 1);

    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        cand_idx;
    logic [PTR_W:0]          cand_sum;
    logic                    grant_valid;
    logic [NUM_WB_UNITS-1:0] grant_vec;

    logic                    commit_q, commit_d;
    logic                    retire_valid_q, retire_valid_d;
    logic [4:0]              rd_addr_q, rd_addr_d;
    logic [31:0]             new_data_q, new_data_d;
    logic [ID_W-1:0]         retire_id_q, retire_id_d;

    // Round-robin search: walk upward from the pointer, wrapping, and take the first requester.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_WB_UNITS; i++) begin
            cand_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (cand_sum >= NUM_W) begin
                cand_sum = cand_sum - NUM_W;
            end
            cand_idx = cand_sum[PTR_W-1:0];
            if (!grant_valid && units.unit_done[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // One-hot grant, suppressed while reset is held so no unit believes it transferred.
    always_comb begin
        grant_vec = '0;
        if (grant_valid && !rst) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    assign units.unit_ack = grant_vec;

    // Next pointer and next output-stage contents; payload holds when nothing is granted.
    always_comb begin
        ptr_d          = ptr_q;
        retire_valid_d = grant_valid;
        commit_d       = 1'b0;
        rd_addr_d      = rd_addr_q;
        new_data_d     = new_data_q;
        retire_id_d    = retire_id_q;
        if (grant_valid) begin
            ptr_d       = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
            commit_d    = (units.unit_rd[grant_idx] != 5'd0);
            rd_addr_d   = units.unit_rd[grant_idx];
            new_data_d  = units.unit_rd_data[grant_idx];
            retire_id_d = units.unit_id[grant_idx];
        end
    end

    // Priority pointer and the single registered output stage; reset discards any in-flight entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q          <= '0;
            commit_q       <= 1'b0;
            retire_valid_q <= 1'b0;
            rd_addr_q      <= '0;
            new_data_q     <= '0;
            retire_id_q    <= '0;
        end else begin
            ptr_q          <= ptr_d;
            commit_q       <= commit_d;
            retire_valid_q <= retire_valid_d;
            rd_addr_q      <= rd_addr_d;
            new_data_q     <= new_data_d;
            retire_id_q    <= retire_id_d;
        end
    end

    assign commit       = commit_q;
    assign retire_valid = retire_valid_q;
    assign rd_addr      = rd_addr_q;
    assign new_data     = new_data_q;
    assign retire_id    = retire_id_q;

`ifdef WB_PERF_COUNTERS_EN
    logic [NUM_WB_UNITS-1:0][31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0]                   commit_cnt_q, commit_cnt_d;

    // A unit stalls on every cycle it requests without being granted; retirements count the stage.
    always_comb begin
        for (int i = 0; i < NUM_WB_UNITS; i++) begin
            stall_cnt_d[i] = stall_cnt_q[i] +
                             ((units.unit_done[i] && !grant_vec[i]) ? 32'd1 : 32'd0);
        end
        commit_cnt_d = commit_cnt_q + (retire_valid_q ? 32'd1 : 32'd0);
    end

    // Free-running wrap-around counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            commit_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_commit_cnt = commit_cnt_q;
`else
    assign perf_stall_cnt  = '0;
    assign perf_commit_cnt = '0;
`endif

`ifndef SYNTHESIS
    logic [NUM_WB_UNITS-1:0] pending_q, pending_d;

    // Units that requested but were not granted must still be requesting next cycle.
    always_comb begin
        pending_d = units.unit_done & ~grant_vec;
    end

    // Remember outstanding requests for the protocol check below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Grant must be one-hot-or-zero, only to requesters, and requesters must not withdraw.
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(grant_vec) && ((grant_vec & ~units.unit_done) == '0));
            assert ((pending_q & ~units.unit_done) == '0);
        end
    end
`endif

endmodule
